// File: rtl/rice_stream_decoder.sv
// Streaming Rice (Golomb power-of-two) block decoder with in-band per-block option IDs.
// MSB-first bitstream words in, N-bit samples out; an all-ones ID selects raw samples.
module rice_stream_decoder #(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned N      = 16,
  parameter int unsigned ID_W   = 4,
  parameter int unsigned J_MAX  = 64,
  parameter int unsigned FS_MAX = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [$clog2(J_MAX+1)-1:0] j,
  input  logic [WORD_W-1:0]          in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [N-1:0]               sym,
  output logic                       sym_valid,
  input  logic                       sym_ready,
  output logic                       sym_last,
  output logic [ID_W-1:0]            blk_k,
  output logic                       err_fs,
  output logic                       err_ovf
);

  localparam int unsigned BUF_W  = 2 * WORD_W;
  localparam int unsigned FILL_W = $clog2(BUF_W + 1);
  localparam int unsigned JW     = $clog2(J_MAX + 1);
  localparam int unsigned FSW    = $clog2(FS_MAX + 1);
  localparam int unsigned KMAX   = (1 << ID_W) - 2;
  localparam int unsigned WIDE_W = (FSW + KMAX > N) ? FSW + KMAX : N + 1;

  localparam logic [2:0] StId   = 3'd0;
  localparam logic [2:0] StFs   = 3'd1;
  localparam logic [2:0] StKb   = 3'd2;
  localparam logic [2:0] StRaw  = 3'd3;
  localparam logic [2:0] StEmit = 3'd4;
  localparam logic [2:0] StHalt = 3'd5;

  logic [BUF_W-1:0]  buf_q, buf_d;
  logic [FILL_W-1:0] fill_q, fill_d, fill_after, consume;
  logic [2:0]        state_q, state_d;
  logic [ID_W-1:0]   blk_k_q, blk_k_d, id_bits;
  logic [JW-1:0]     j_q, j_d, cnt_q, cnt_d;
  logic [FSW-1:0]    fs_q, fs_d;
  logic [N-1:0]      sym_q, sym_d, kbits;
  logic              sym_valid_q, sym_valid_d, sym_last_q, sym_last_d;
  logic              err_fs_q, err_fs_d, err_ovf_q, err_ovf_d;
  logic [WIDE_W-1:0] fs_shift;
  logic              ovf, load;

  assign in_ready  = !reset && (fill_q <= FILL_W'(WORD_W)) && (state_q != StHalt);
  assign load      = in_valid && in_ready;
  assign id_bits   = buf_q[BUF_W-1 -: ID_W];
  // Remainder bits sit at the top of the buffer; right-justify them.
  assign kbits     = N'(buf_q >> (FILL_W'(BUF_W) - FILL_W'(blk_k_q)));
  assign fs_shift  = {{(WIDE_W-FSW){1'b0}}, fs_q} << blk_k_q;
  assign ovf       = |(fs_shift >> N);

  assign sym       = sym_q;
  assign sym_valid = sym_valid_q;
  assign sym_last  = sym_last_q;
  assign blk_k     = blk_k_q;
  assign err_fs    = err_fs_q;
  assign err_ovf   = err_ovf_q;

  always_comb begin
    state_d     = state_q;
    blk_k_d     = blk_k_q;
    j_d         = j_q;
    cnt_d       = cnt_q;
    fs_d        = fs_q;
    sym_d       = sym_q;
    sym_valid_d = sym_valid_q;
    sym_last_d  = sym_last_q;
    err_fs_d    = err_fs_q;
    err_ovf_d   = err_ovf_q;
    consume     = '0;

    unique case (state_q)
      StId: begin
        if (fill_q >= FILL_W'(ID_W)) begin
          consume = FILL_W'(ID_W);
          blk_k_d = id_bits;
          j_d     = (j == '0) ? JW'(J_MAX) : j;
          cnt_d   = '0;
          fs_d    = '0;
          state_d = (&id_bits) ? StRaw : StFs;
        end
      end
      StFs: begin
        if (fill_q != '0) begin
          consume = FILL_W'(1);
          if (!buf_q[BUF_W-1]) begin
            if (fs_q == FSW'(FS_MAX)) begin
              err_fs_d = 1'b1;
              state_d  = StHalt;
            end else begin
              fs_d = fs_q + FSW'(1);
            end
          end else if (blk_k_q != '0) begin
            state_d = StKb;
          end else begin
            sym_d       = fs_shift[N-1:0];
            err_ovf_d   = err_ovf_q | ovf;
            sym_valid_d = 1'b1;
            sym_last_d  = (cnt_q == j_q - JW'(1));
            state_d     = StEmit;
          end
        end
      end
      StKb: begin
        if (fill_q >= FILL_W'(blk_k_q)) begin
          consume     = FILL_W'(blk_k_q);
          sym_d       = fs_shift[N-1:0] | kbits;
          err_ovf_d   = err_ovf_q | ovf;
          sym_valid_d = 1'b1;
          sym_last_d  = (cnt_q == j_q - JW'(1));
          state_d     = StEmit;
        end
      end
      StRaw: begin
        if (fill_q >= FILL_W'(N)) begin
          consume     = FILL_W'(N);
          sym_d       = buf_q[BUF_W-1 -: N];
          sym_valid_d = 1'b1;
          sym_last_d  = (cnt_q == j_q - JW'(1));
          state_d     = StEmit;
        end
      end
      StEmit: begin
        if (sym_ready) begin
          sym_valid_d = 1'b0;
          sym_last_d  = 1'b0;
          cnt_d       = cnt_q + JW'(1);
          fs_d        = '0;
          state_d     = sym_last_q ? StId : ((&blk_k_q) ? StRaw : StFs);
        end
      end
      StHalt: ;
      default: state_d = StId;
    endcase

    // New word lands directly below whatever survives this cycle's consume.
    fill_after = fill_q - consume;
    buf_d      = buf_q << consume;
    fill_d     = fill_after;
    if (load) begin
      buf_d  = buf_d | ({in_data, {WORD_W{1'b0}}} >> fill_after);
      fill_d = fill_after + FILL_W'(WORD_W);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      buf_q       <= '0;
      fill_q      <= '0;
      state_q     <= StId;
      blk_k_q     <= '0;
      j_q         <= '0;
      cnt_q       <= '0;
      fs_q        <= '0;
      sym_q       <= '0;
      sym_valid_q <= 1'b0;
      sym_last_q  <= 1'b0;
      err_fs_q    <= 1'b0;
      err_ovf_q   <= 1'b0;
    end else begin
      buf_q       <= buf_d;
      fill_q      <= fill_d;
      state_q     <= state_d;
      blk_k_q     <= blk_k_d;
      j_q         <= j_d;
      cnt_q       <= cnt_d;
      fs_q        <= fs_d;
      sym_q       <= sym_d;
      sym_valid_q <= sym_valid_d;
      sym_last_q  <= sym_last_d;
      err_fs_q    <= err_fs_d;
      err_ovf_q   <= err_ovf_d;
    end
  end

endmodule

// File: tb/tb_rice_stream_decoder.sv
// Bench for rice_stream_decoder: directed cases plus random block streams encoded by a
// bit-level Rice encoder model, with outputs compared at every sink handshake.
module tb_rice_stream_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  j;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] sym;
  logic        sym_valid;
  logic        sym_ready;
  logic        sym_last;
  logic [3:0]  blk_k;
  logic        err_fs;
  logic        err_ovf;

  rice_stream_decoder #(
    .WORD_W(32), .N(16), .ID_W(4), .J_MAX(64), .FS_MAX(64)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .j         (j),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sym       (sym),
    .sym_valid (sym_valid),
    .sym_ready (sym_ready),
    .sym_last  (sym_last),
    .blk_k     (blk_k),
    .err_fs    (err_fs),
    .err_ovf   (err_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] v;
    logic        last;
    logic [3:0]  k;
  } exp_t;

  bit          bits_q[$];
  logic [31:0] words[$];
  exp_t        exp_q[$];
  int          total;
  int          passed;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
  endtask

  function automatic void push_bits(input logic [31:0] val, input int n);
    for (int i = n - 1; i >= 0; i--) bits_q.push_back(val[i]);
  endfunction

  function automatic void push_zeros(input int n);
    for (int i = 0; i < n; i++) bits_q.push_back(1'b0);
  endfunction

  function automatic void push_exp(input int v, input bit last, input int k);
    exp_t e;
    e.v = 16'(v);
    e.last = last;
    e.k = 4'(k);
    exp_q.push_back(e);
  endfunction

  function automatic void pack();
    logic [31:0] w;
    bit b;
    while (bits_q.size() > 0) begin
      w = '0;
      for (int i = 0; i < 32; i++) begin
        b = 1'b0;
        if (bits_q.size() > 0) b = bits_q.pop_front();
        w = {w[30:0], b};
      end
      words.push_back(w);
    end
  endfunction

  // Encode one block of random samples; values stay in range so no overflow is expected.
  function automatic void add_block(input int id, input int jj);
    int nsamp, maxfs, fs, r, v;
    nsamp = (jj == 0) ? 64 : jj;
    push_bits(id, 4);
    for (int s = 0; s < nsamp; s++) begin
      if (id == 15) begin
        v = int'($urandom_range(0, 65535));
        push_bits(v, 16);
      end else begin
        maxfs = 65535 >> id;
        if (maxfs > 64) maxfs = 64;
        if ($urandom_range(0, 15) == 0) fs = maxfs;
        else fs = int'($urandom_range(0, (maxfs < 6) ? maxfs : 6));
        r = (id == 0) ? 0 : int'($urandom_range(0, (1 << id) - 1));
        v = (fs << id) + r;
        push_zeros(fs);
        push_bits(1, 1);
        if (id > 0) push_bits(r, id);
      end
      push_exp(v, s == nsamp - 1, id);
    end
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    sym_ready = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_sym", sym, 0);
    chk("rst_sym_valid", sym_valid, 0);
    chk("rst_sym_last", sym_last, 0);
    chk("rst_blk_k", blk_k, 0);
    chk("rst_err_fs", err_fs, 0);
    chk("rst_err_ovf", err_ovf, 0);
    chk("post_rst_in_ready", in_ready, 1);
    bits_q.delete();
    words.delete();
    exp_q.delete();
  endtask

  // Feed words from index start and check every sink handshake against exp_q.
  task automatic run(input int start, input int vp, input int rp, input int budget);
    int   widx, cyc;
    logic acc, pending, plast;
    logic [15:0] psym;
    exp_t e;
    widx = start;
    cyc = 0;
    pending = 1'b0;
    psym = '0;
    plast = 1'b0;
    while (exp_q.size() > 0 && cyc < budget) begin
      @(negedge clk);
      cyc++;
      acc = in_valid && in_ready;
      if (pending) begin
        chk("hold_valid", sym_valid, 1);
        chk("hold_sym", sym, psym);
        chk("hold_last", sym_last, plast);
      end
      pending = 1'b0;
      if (sym_valid && sym_ready) begin
        e = exp_q.pop_front();
        chk("sym", sym, e.v);
        chk("sym_last", sym_last, e.last);
        chk("blk_k", blk_k, e.k);
      end else if (sym_valid) begin
        pending = 1'b1;
        psym = sym;
        plast = sym_last;
      end
      @(posedge clk); #1;
      if (acc) widx++;
      in_valid = (widx < words.size()) && ($urandom_range(0, 99) < vp);
      in_data = in_valid ? words[widx] : '0;
      sym_ready = ($urandom_range(0, 99) < rp);
    end
    chk("samples_left", exp_q.size(), 0);
    in_valid = 1'b0;
    sym_ready = 1'b0;
  endtask

  initial begin
    total = 0;
    passed = 0;
    reset = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    sym_ready = 1'b0;
    j = '0;

    // Basic Rice block, k=2: samples 5 and 3.
    j = 7'd2;
    do_reset();
    words.push_back(32'h25E0_0000);
    push_exp(5, 0, 2);
    push_exp(3, 1, 2);
    run(0, 100, 100, 200);
    chk("t1_err_fs", err_fs, 0);
    chk("t1_err_ovf", err_ovf, 0);

    // Raw block, k=0 sample at the FS_MAX limit, raw sample straddling a word boundary.
    j = 7'd1;
    do_reset();
    push_bits(15, 4);
    push_bits(16'hABCD, 16);
    push_exp(16'hABCD, 1, 15);
    push_bits(0, 4);
    push_zeros(64);
    push_bits(1, 1);
    push_exp(64, 1, 0);
    push_bits(15, 4);
    push_bits(16'h8421, 16);
    push_exp(16'h8421, 1, 15);
    pack();
    chk("t2_word0", words[0], 32'hFABC_D000);
    run(0, 70, 70, 600);
    chk("t2_err_fs", err_fs, 0);

    // Back-pressure: buffer fills, in_ready drops, stalled sample holds steady.
    j = 7'd1;
    do_reset();
    words.push_back(32'hFABC_DF12);
    words.push_back(32'h34F5_678F);
    words.push_back(32'h9ABC_0000);
    push_exp(16'hABCD, 1, 15);
    push_exp(16'h1234, 1, 15);
    push_exp(16'h5678, 1, 15);
    push_exp(16'h9ABC, 1, 15);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data = words[0];
    @(negedge clk);
    chk("t3_ready_w0", in_ready, 1);
    @(posedge clk); #1;
    in_data = words[1];
    @(negedge clk);
    chk("t3_ready_w1", in_ready, 1);
    @(posedge clk); #1;
    in_data = words[2];
    @(negedge clk);
    chk("t3_ready_full", in_ready, 0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("t3_stall_valid", sym_valid, 1);
      chk("t3_stall_sym", sym, 16'hABCD);
      chk("t3_stall_last", sym_last, 1);
      chk("t3_stall_ready", in_ready, 0);
    end
    run(2, 100, 100, 300);

    // FS overflow: ID 0 followed by zeros halts the decoder.
    j = 7'd1;
    do_reset();
    begin
      int sent;
      sent = 0;
      for (int c = 0; c < 150; c++) begin
        @(negedge clk);
        if (in_valid && in_ready) sent++;
        @(posedge clk); #1;
        in_valid = (sent < 3);
        in_data = '0;
        sym_ready = 1'b1;
      end
      chk("t4_words_sent", sent, 3);
    end
    @(negedge clk);
    chk("t4_err_fs", err_fs, 1);
    chk("t4_in_ready", in_ready, 0);
    chk("t4_sym_valid", sym_valid, 0);
    chk("t4_err_ovf", err_ovf, 0);
    do_reset();

    // Overflow: k=14, fs=4 truncates to the remainder; next block still decodes.
    j = 7'd1;
    do_reset();
    push_bits(14, 4);
    push_zeros(4);
    push_bits(1, 1);
    push_bits(14'h1ABC, 14);
    push_exp(16'h1ABC, 1, 14);
    push_bits(2, 4);
    push_bits(1, 1);
    push_bits(1, 2);
    push_exp(1, 1, 2);
    pack();
    run(0, 100, 100, 200);
    chk("t5_err_ovf", err_ovf, 1);
    chk("t5_err_fs", err_fs, 0);

    // Reset mid-block, then a fresh stream.
    j = 7'd4;
    do_reset();
    add_block(3, 4);
    pack();
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data = words[0];
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    j = 7'd2;
    do_reset();
    words.push_back(32'h25E0_0000);
    push_exp(5, 0, 2);
    push_exp(3, 1, 2);
    run(0, 100, 100, 200);

    // Random multi-block streams, j=0 standing for 64 samples on the last pass.
    for (int t = 0; t < 5; t++) begin
      int jj;
      jj = (t == 4) ? 0 : int'($urandom_range(1, 8));
      j = 7'(jj);
      do_reset();
      for (int b = 0; b < ((jj == 0) ? 1 : 3); b++) add_block(int'($urandom_range(0, 15)), jj);
      pack();
      run(0, 60, 60, 20000);
      chk("rand_err_fs", err_fs, 0);
      chk("rand_err_ovf", err_ovf, 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
